// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: one-outstanding imem requests, redirect drain, 1-entry slot.
// Optional MISALIGN_TRAP_EN adds a trap state for misaligned redirects.
module fetch_pc_unit #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [BUS_DATA_WIDTH-1:0] inBta,
  input  logic                      inBranchTaken,
  input  logic                      inStall,
  output logic                      outImemReqValid,
  output logic [BUS_DATA_WIDTH-1:0] outImemAddr,
  input  logic                      inImemAck,
  input  logic [INSTR_WIDTH-1:0]    inImemData,
  output logic                      outValid,
  input  logic                      inReady,
  output logic [INSTR_WIDTH-1:0]    outInstr,
  output logic [BUS_DATA_WIDTH-1:0] outPc
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                      outMisaligned
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN
`ifdef MISALIGN_TRAP_EN
    ,
    S_TRAP
`endif
  } state_e;

  localparam logic [BUS_DATA_WIDTH-1:0] PC_STEP =
    BUS_DATA_WIDTH'(4);
  localparam logic [BUS_DATA_WIDTH-1:0] ALIGN_MASK =
    ~BUS_DATA_WIDTH'(3);

  state_e                    state_q;
  logic [BUS_DATA_WIDTH-1:0] pc_q;
  logic [BUS_DATA_WIDTH-1:0] drainPc_q;
  logic                      pending_q;
  logic                      valid_q;
  logic [INSTR_WIDTH-1:0]    instr_q;
  logic [BUS_DATA_WIDTH-1:0] slotPc_q;

  logic                      slotFree;
  logic                      req;
  logic                      ack;
  logic [BUS_DATA_WIDTH-1:0] btaAl;

  assign btaAl    = inBta & ALIGN_MASK;
  assign slotFree = ~valid_q | inReady;
  // A pending request is held regardless of stall, slot or redirect.
  assign req = pending_q |
               ((state_q == S_REQ) & ~inStall & slotFree);
  assign ack = req & inImemAck;

  assign outImemReqValid = req;
  assign outImemAddr     = req ? pc_q : '0;
  assign outValid        = valid_q;
  assign outInstr        = instr_q;
  assign outPc           = slotPc_q;

`ifdef MISALIGN_TRAP_EN
  logic misTgt;
  logic drainMis_q;

  assign misTgt        = |inBta[1:0];
  assign outMisaligned = (state_q == S_TRAP);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      drainPc_q  <= '0;
      pending_q  <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      slotPc_q   <= '0;
`ifdef MISALIGN_TRAP_EN
      drainMis_q <= 1'b0;
`endif
    end else begin
      pending_q <= req & ~inImemAck;
      if (inBranchTaken) begin
        valid_q <= 1'b0;
        if (req && !inImemAck) begin
          drainPc_q <= btaAl;
          state_q   <= S_DRAIN;
`ifdef MISALIGN_TRAP_EN
          drainMis_q <= misTgt;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
          if (misTgt) begin
            state_q <= S_TRAP;
          end else begin
            pc_q    <= btaAl;
            state_q <= S_REQ;
          end
`else
          pc_q    <= btaAl;
          state_q <= S_REQ;
`endif
        end
      end else begin
        if (ack && state_q != S_DRAIN) begin
          valid_q  <= 1'b1;
          instr_q  <= inImemData;
          slotPc_q <= pc_q;
          pc_q     <= pc_q + PC_STEP;
        end else if (inReady) begin
          valid_q <= 1'b0;
        end
        unique case (state_q)
          S_IDLE: state_q <= S_REQ;
          S_REQ: begin
            if (!req) state_q <= S_HOLD;
          end
          S_HOLD: begin
            if (!inStall && slotFree) state_q <= S_REQ;
          end
          S_DRAIN: begin
            if (ack) begin
`ifdef MISALIGN_TRAP_EN
              if (!drainMis_q) pc_q <= drainPc_q;
              state_q <= drainMis_q ? S_TRAP : S_REQ;
`else
              pc_q    <= drainPc_q;
              state_q <= S_REQ;
`endif
            end
          end
`ifdef MISALIGN_TRAP_EN
          S_TRAP: valid_q <= 1'b0;
`endif
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus a randomized run
// against a transaction-level fetch model.
module tb_fetch_pc_unit;

  localparam int BW = 64;
  localparam int IW = 32;
  localparam logic [BW-1:0] RPC = 64'h1000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [BW-1:0] inBta;
  logic          inBranchTaken;
  logic          inStall;
  logic          outImemReqValid;
  logic [BW-1:0] outImemAddr;
  logic          inImemAck;
  logic [IW-1:0] inImemData;
  logic          outValid;
  logic          inReady;
  logic [IW-1:0] outInstr;
  logic [BW-1:0] outPc;
`ifdef MISALIGN_TRAP_EN
  logic          outMisaligned;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] memWord(input logic [BW-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  assign inImemData = memWord(outImemAddr);

  fetch_pc_unit #(
    .BUS_DATA_WIDTH(BW),
    .INSTR_WIDTH(IW),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .inBta(inBta),
    .inBranchTaken(inBranchTaken),
    .inStall(inStall),
    .outImemReqValid(outImemReqValid),
    .outImemAddr(outImemAddr),
    .inImemAck(inImemAck),
    .inImemData(inImemData),
    .outValid(outValid),
    .inReady(inReady),
    .outInstr(outInstr),
    .outPc(outPc)
`ifdef MISALIGN_TRAP_EN
    ,
    .outMisaligned(outMisaligned)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Leaves the bench just after reset release, before edge 0.
  task automatic do_reset();
    inBranchTaken = 1'b0;
    inStall       = 1'b0;
    inBta         = '0;
    inImemAck     = 1'b1;
    inReady       = 1'b1;
    reset_n       = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    inBranchTaken = 1'b0;
    inStall       = 1'b0;
    inBta         = '0;
    inImemAck     = 1'b1;
    inReady       = 1'b1;
    reset_n       = 1'b0;
    tick();
    smp();
    checks++;
    if (outImemReqValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_req got=%b exp=0", outImemReqValid);
    end
    checks++;
    if (outImemAddr !== '0) begin
      errors++;
      $display("FAIL reset_addr got=%h exp=0", outImemAddr);
    end
    checks++;
    if (outValid !== 1'b0 || outInstr !== '0 || outPc !== '0) begin
      errors++;
      $display("FAIL reset_slot got=%b/%h/%h exp=0/0/0",
               outValid, outInstr, outPc);
    end
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (outMisaligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_mis got=%b exp=0", outMisaligned);
    end
`endif
    tick();
    reset_n = 1'b1;
    smp();
    checks++;
    if (outImemReqValid !== 1'b0) begin
      errors++;
      $display("FAIL idle_req got=%b exp=0", outImemReqValid);
    end
  endtask

  task automatic test_seq();
    logic [BW-1:0] ea;
    for (int i = 0; i < 3; i++) begin
      tick();
      smp();
      ea = RPC + BW'(4 * i);
      checks++;
      if (outImemReqValid !== 1'b1 || outImemAddr !== ea) begin
        errors++;
        $display("FAIL seq_req%0d got=%b/%h exp=1/%h",
                 i, outImemReqValid, outImemAddr, ea);
      end
      if (i > 0) begin
        checks++;
        if (outValid !== 1'b1 || outPc !== ea - 4 ||
            outInstr !== memWord(ea - 4)) begin
          errors++;
          $display("FAIL seq_slot%0d got=%b/%h/%h exp=1/%h/%h",
                   i, outValid, outPc, outInstr, ea - 4,
                   memWord(ea - 4));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit found;
    do_reset();
    tick();
    smp();
    checks++;
    if (outImemReqValid !== 1'b1 || outImemAddr !== RPC) begin
      errors++;
      $display("FAIL bp_first got=%b/%h exp=1/%h",
               outImemReqValid, outImemAddr, RPC);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      inReady = 1'b0;
      smp();
      checks++;
      if (outImemReqValid !== 1'b0 || outValid !== 1'b1 ||
          outPc !== RPC || outInstr !== memWord(RPC)) begin
        errors++;
        $display("FAIL bp_hold%0d got=%b/%b/%h/%h exp=0/1/%h/%h",
                 i, outImemReqValid, outValid, outPc, outInstr,
                 RPC, memWord(RPC));
      end
    end
    tick();
    inReady = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp();
      if (outImemReqValid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found || outImemAddr !== RPC + 4) begin
      errors++;
      $display("FAIL bp_resume got=%b/%h exp=1/%h",
               found, outImemAddr, RPC + 4);
    end
  endtask

  task automatic test_drain();
    do_reset();
    tick();
    tick();
    tick();
    inImemAck     = 1'b0;
    inBranchTaken = 1'b1;
    inBta         = 64'h2000;
    smp();
    checks++;
    if (outImemReqValid !== 1'b1 || outImemAddr !== 64'h1008) begin
      errors++;
      $display("FAIL dr_req got=%b/%h exp=1/1008",
               outImemReqValid, outImemAddr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      inBranchTaken = 1'b0;
      if (i == 3) inImemAck = 1'b1;
      smp();
      checks++;
      if (outImemReqValid !== 1'b1 || outImemAddr !== 64'h1008 ||
          outValid !== 1'b0) begin
        errors++;
        $display("FAIL dr_wait%0d got=%b/%h/%b exp=1/1008/0",
                 i, outImemReqValid, outImemAddr, outValid);
      end
    end
    tick();
    smp();
    checks++;
    if (outImemReqValid !== 1'b1 || outImemAddr !== 64'h2000 ||
        outValid !== 1'b0) begin
      errors++;
      $display("FAIL dr_target got=%b/%h/%b exp=1/2000/0",
               outImemReqValid, outImemAddr, outValid);
    end
    tick();
    smp();
    checks++;
    if (outValid !== 1'b1 || outPc !== 64'h2000 ||
        outInstr !== memWord(64'h2000)) begin
      errors++;
      $display("FAIL dr_slot got=%b/%h/%h exp=1/2000/%h",
               outValid, outPc, outInstr, memWord(64'h2000));
    end
  endtask

  task automatic test_stall_redirect();
    bit found;
    tick();
    inStall       = 1'b1;
    inBranchTaken = 1'b1;
    inBta         = 64'h3000;
    smp();
    for (int i = 0; i < 3; i++) begin
      tick();
      inBranchTaken = 1'b0;
      smp();
      checks++;
      if (outValid !== 1'b0 || outImemReqValid !== 1'b0) begin
        errors++;
        $display("FAIL st_hold%0d got=%b/%b exp=0/0",
                 i, outValid, outImemReqValid);
      end
    end
    tick();
    inStall = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp();
      if (outImemReqValid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found || outImemAddr !== 64'h3000) begin
      errors++;
      $display("FAIL st_resume got=%b/%h exp=1/3000",
               found, outImemAddr);
    end
  endtask

  task automatic test_wrap();
    tick();
    inBranchTaken = 1'b1;
    inBta         = 64'hFFFF_FFFF_FFFF_FFFC;
    smp();
    tick();
    inBranchTaken = 1'b0;
    smp();
    checks++;
    if (outImemReqValid !== 1'b1 ||
        outImemAddr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_top got=%b/%h exp=1/fffffffffffffffc",
               outImemReqValid, outImemAddr);
    end
    tick();
    smp();
    checks++;
    if (outImemReqValid !== 1'b1 || outImemAddr !== '0 ||
        outPc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_zero got=%b/%h/%h exp=1/0/fffffffffffffffc",
               outImemReqValid, outImemAddr, outPc);
    end
  endtask

  task automatic test_misalign();
    tick();
    inBranchTaken = 1'b1;
    inBta         = 64'h2002;
    smp();
    tick();
    inBranchTaken = 1'b0;
    smp();
`ifdef MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        tick();
        smp();
      end
      checks++;
      if (outMisaligned !== 1'b1 || outImemReqValid !== 1'b0 ||
          outValid !== 1'b0) begin
        errors++;
        $display("FAIL trap%0d got=%b/%b/%b exp=1/0/0",
                 i, outMisaligned, outImemReqValid, outValid);
      end
    end
    tick();
    inBranchTaken = 1'b1;
    inBta         = 64'h4000;
    smp();
    tick();
    inBranchTaken = 1'b0;
    smp();
    checks++;
    if (outMisaligned !== 1'b0 || outImemReqValid !== 1'b1 ||
        outImemAddr !== 64'h4000) begin
      errors++;
      $display("FAIL trap_exit got=%b/%b/%h exp=0/1/4000",
               outMisaligned, outImemReqValid, outImemAddr);
    end
    tick();
    smp();
    checks++;
    if (outValid !== 1'b1 || outPc !== 64'h4000) begin
      errors++;
      $display("FAIL trap_slot got=%b/%h exp=1/4000",
               outValid, outPc);
    end
`else
    checks++;
    if (outImemReqValid !== 1'b1 || outImemAddr !== 64'h2000) begin
      errors++;
      $display("FAIL align got=%b/%h exp=1/2000",
               outImemReqValid, outImemAddr);
    end
`endif
  endtask

  // Model: expected fetch stream, slot contents and drain discards.
  task automatic test_random();
    bit            mValid;
    logic [BW-1:0] mPc;
    logic [IW-1:0] mInstr;
    logic [BW-1:0] expNext;
    logic [BW-1:0] prevAddr;
    bit            stale;
    bit            prevPend;
    bit            req;
    logic [BW-1:0] addr;
    int            delivered;
    do_reset();
    mValid    = 1'b0;
    mPc       = '0;
    mInstr    = '0;
    expNext   = RPC;
    prevAddr  = '0;
    stale     = 1'b0;
    prevPend  = 1'b0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      inStall       = ($urandom_range(0, 4) == 0);
      inReady       = ($urandom_range(0, 3) != 0);
      inImemAck     = ($urandom_range(0, 2) != 0);
      inBranchTaken = ($urandom_range(0, 29) == 0);
      inBta         = {$urandom(), $urandom()};
`ifdef MISALIGN_TRAP_EN
      inBta[1:0] = 2'b00;
`endif
      smp();
      req  = outImemReqValid;
      addr = outImemAddr;
      checks++;
      if (outValid !== mValid) begin
        errors++;
        $display("FAIL rnd_valid c%0d got=%b exp=%b",
                 c, outValid, mValid);
      end
      if (mValid) begin
        checks++;
        if (outPc !== mPc || outInstr !== mInstr) begin
          errors++;
          $display("FAIL rnd_slot c%0d got=%h/%h exp=%h/%h",
                   c, outPc, outInstr, mPc, mInstr);
        end
      end
      if (prevPend) begin
        checks++;
        if (req !== 1'b1 || addr !== prevAddr) begin
          errors++;
          $display("FAIL rnd_hold c%0d got=%b/%h exp=1/%h",
                   c, req, addr, prevAddr);
        end
      end
      if (req && !stale) begin
        checks++;
        if (addr !== expNext) begin
          errors++;
          $display("FAIL rnd_addr c%0d got=%h exp=%h",
                   c, addr, expNext);
        end
      end
      if (req && !prevPend) begin
        checks++;
        if (inStall || (mValid && !inReady)) begin
          errors++;
          $display("FAIL rnd_issue c%0d got=req exp=no_req stall=%b",
                   c, inStall);
        end
      end
      if (inBranchTaken) begin
        mValid  = 1'b0;
        stale   = req && !inImemAck;
        expNext = inBta & ~64'h3;
      end else if (req && inImemAck && !stale) begin
        mValid  = 1'b1;
        mPc     = expNext;
        mInstr  = memWord(expNext);
        expNext = expNext + 4;
        delivered++;
      end else begin
        if (req && inImemAck) stale = 1'b0;
        if (inReady) mValid = 1'b0;
      end
      prevPend = req && !inImemAck;
      prevAddr = addr;
    end
    checks++;
    if (delivered < 200) begin
      errors++;
      $display("FAIL rnd_progress got=%0d exp>=200", delivered);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_seq();
    test_backpressure();
    test_drain();
    test_stall_redirect();
    test_wrap();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
